// File: rtl/stream_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module   : stream_rr_arb
//  Brief    : N-input round-robin valid/ready stream merger with a registered
//             two-entry skid output. Define STREAM_ARB_LOCK_EN to hold a grant
//             until the granted input sends its last beat (packet locking).
//  Revision : 1.0  initial release
// ============================================================================
module stream_rr_arb #(
    parameter int N_INPUTS   = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N_INPUTS*DATA_WIDTH-1:0] idat,
    input  logic [N_INPUTS-1:0]            ilst,
    input  logic [N_INPUTS-1:0]            ivld,
    output logic [N_INPUTS-1:0]            irdy,
    output logic [DATA_WIDTH-1:0]          odat,
    output logic                           olst,
    output logic [$clog2(N_INPUTS)-1:0]    osel,
    output logic                           ovld,
    input  logic                           ordy
);

    localparam int SEL_W = $clog2(N_INPUTS);

    logic [SEL_W-1:0]      r_ptr;
    logic [DATA_WIDTH-1:0] r_o_dat;
    logic                  r_o_lst;
    logic [SEL_W-1:0]      r_o_sel;
    logic                  r_o_vld;
    logic [DATA_WIDTH-1:0] r_s_dat;
    logic                  r_s_lst;
    logic [SEL_W-1:0]      r_s_sel;
    logic                  r_s_vld;

    logic                  w_scan_vld;
    logic [SEL_W-1:0]      w_scan_idx;
    logic                  w_lock_act;
    logic [SEL_W-1:0]      w_lock_idx;
    logic                  w_gnt_vld;
    logic [SEL_W-1:0]      w_gnt_idx;
    logic [SEL_W-1:0]      w_gnt_nxt;
    logic                  w_gnt_lst;
    logic [DATA_WIDTH-1:0] w_gnt_dat;
    logic                  w_accept;
    logic                  w_xfer;
    logic                  w_o_free;
    logic                  w_ptr_adv;

    // First requester at or after r_ptr, wrapping modulo N_INPUTS.
    always_comb begin
        int v_idx;
        v_idx      = 0;
        w_scan_vld = 1'b0;
        w_scan_idx = '0;
        for (int k = 0; k < N_INPUTS; k++) begin
            v_idx = int'(r_ptr) + k;
            if (v_idx >= N_INPUTS) begin
                v_idx = v_idx - N_INPUTS;
            end
            if (!w_scan_vld && ivld[SEL_W'(v_idx)]) begin
                w_scan_vld = 1'b1;
                w_scan_idx = SEL_W'(v_idx);
            end
        end
    end

    assign w_gnt_vld = w_lock_act | w_scan_vld;
    assign w_gnt_idx = w_lock_act ? w_lock_idx : w_scan_idx;
    assign w_gnt_nxt = (w_gnt_idx == SEL_W'(N_INPUTS - 1)) ? '0 : w_gnt_idx + SEL_W'(1);
    assign w_gnt_lst = ilst[w_gnt_idx];
    assign w_gnt_dat = idat[w_gnt_idx*DATA_WIDTH +: DATA_WIDTH];

    // Acceptance depends only on registered skid occupancy, never on ordy.
    assign w_accept  = !r_s_vld;
    assign w_o_free  = !r_o_vld || ordy;
    assign w_xfer    = w_gnt_vld && w_accept && ivld[w_gnt_idx];
    assign irdy      = (rst_n && w_accept && w_gnt_vld) ? (N_INPUTS'(1) << w_gnt_idx) : '0;

`ifdef STREAM_ARB_LOCK_EN
    logic             r_lock;
    logic [SEL_W-1:0] r_lock_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
        end else if (w_xfer) begin
            if (w_gnt_lst) begin
                r_lock <= 1'b0;
            end else begin
                r_lock     <= 1'b1;
                r_lock_idx <= w_gnt_idx;
            end
        end
    end

    assign w_lock_act = r_lock;
    assign w_lock_idx = r_lock_idx;
    assign w_ptr_adv  = w_gnt_lst;
`else
    assign w_lock_act = 1'b0;
    assign w_lock_idx = '0;
    assign w_ptr_adv  = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= '0;
            r_o_vld <= 1'b0;
            r_o_dat <= '0;
            r_o_lst <= 1'b0;
            r_o_sel <= '0;
            r_s_vld <= 1'b0;
            r_s_dat <= '0;
            r_s_lst <= 1'b0;
            r_s_sel <= '0;
        end else begin
            if (r_s_vld) begin
                // Skid drains first; input side is stalled this cycle.
                if (w_o_free) begin
                    r_o_dat <= r_s_dat;
                    r_o_lst <= r_s_lst;
                    r_o_sel <= r_s_sel;
                    r_o_vld <= 1'b1;
                    r_s_vld <= 1'b0;
                end
            end else if (w_xfer) begin
                if (w_o_free) begin
                    r_o_dat <= w_gnt_dat;
                    r_o_lst <= w_gnt_lst;
                    r_o_sel <= w_gnt_idx;
                    r_o_vld <= 1'b1;
                end else begin
                    r_s_dat <= w_gnt_dat;
                    r_s_lst <= w_gnt_lst;
                    r_s_sel <= w_gnt_idx;
                    r_s_vld <= 1'b1;
                end
            end else if (ordy) begin
                r_o_vld <= 1'b0;
            end

            if (w_xfer && w_ptr_adv) begin
                r_ptr <= w_gnt_nxt;
            end
        end
    end

    assign ovld = r_o_vld;
    assign odat = r_o_dat;
    assign olst = r_o_lst;
    assign osel = r_o_sel;

endmodule
`default_nettype wire

// File: tb/tb_stream_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stream_rr_arb
//  Brief    : Randomized scoreboard bench for stream_rr_arb (4 inputs, 32 bit).
//  Revision : 1.0  initial release
// ============================================================================
module tb_stream_rr_arb;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N*DW-1:0] idat;
    logic [N-1:0]    ilst;
    logic [N-1:0]    ivld;
    logic [N-1:0]    irdy;
    logic [DW-1:0]   odat;
    logic            olst;
    logic [SW-1:0]   osel;
    logic            ovld;
    logic            ordy;

    stream_rr_arb #(.N_INPUTS(N), .DATA_WIDTH(DW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .idat (idat),
        .ilst (ilst),
        .ivld (ivld),
        .irdy (irdy),
        .odat (odat),
        .olst (olst),
        .osel (osel),
        .ovld (ovld),
        .ordy (ordy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [SW-1:0] sel;
        logic          lst;
        logic [DW-1:0] dat;
    } beat_t;

    beat_t         exp_q[$];
    int            n_chk  = 0;
    int            n_pass = 0;

    // Pending beat per input (what the source is currently offering).
    bit            pend[N];
    logic [DW-1:0] pdat[N];
    bit            plst[N];

    // Reference model: output buffer seen as a 2-deep FIFO, plus arbitration state.
    int            m_occ;
    int            m_ptr;
    int            m_lock;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endfunction

    function automatic int m_grant();
        if (m_lock >= 0) return m_lock;
        for (int k = 0; k < N; k++) begin
            if (pend[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    // One cycle of stimulus, starting and ending at a falling edge.
    task automatic step(input logic [N-1:0] mask, input int p_new, input int p_ordy, input int p_last);
        int         g;
        bit         acc;
        bit         xf;
        logic [N-1:0] eir;
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && mask[i] && ($urandom_range(99) < p_new)) begin
                pend[i] = 1'b1;
                pdat[i] = $urandom;
                plst[i] = ($urandom_range(99) < p_last);
            end
            ivld[i]           = pend[i];
            ilst[i]           = plst[i];
            idat[i*DW +: DW]  = pdat[i];
        end
        ordy = ($urandom_range(99) < p_ordy);
        acc  = (m_occ < 2);
        g    = m_grant();
        eir  = (acc && g >= 0) ? (N'(1) << g) : '0;
        #1;
        chk("irdy", 64'(irdy), 64'(eir));
        chk("ovld", 64'(ovld), 64'(m_occ > 0));
        xf = acc && (g >= 0) && pend[g];
        if (xf) begin
            exp_q.push_back('{sel: SW'(g), lst: plst[g], dat: pdat[g]});
            pend[g] = 1'b0;
`ifdef STREAM_ARB_LOCK_EN
            if (plst[g]) begin
                m_lock = -1;
                m_ptr  = (g + 1) % N;
            end else begin
                m_lock = g;
            end
`else
            m_ptr = (g + 1) % N;
`endif
        end
        m_occ = m_occ - ((m_occ > 0 && ordy) ? 1 : 0) + (xf ? 1 : 0);
        @(negedge clk);
    endtask

    // Asynchronous reset asserted mid-cycle, held across one rising edge.
    task automatic do_reset();
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_ovld", 64'(ovld), 64'd0);
        chk("rst_irdy", 64'(irdy), 64'd0);
        exp_q.delete();
        m_occ  = 0;
        m_ptr  = 0;
        m_lock = -1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Output monitor: pops the scoreboard whenever a beat leaves the DUT.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && ovld && ordy) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'(ovld), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", 64'({osel, olst, odat}), 64'(e));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int npend;
        rst_n  = 1'b0;
        ivld   = '0;
        ilst   = '0;
        idat   = '0;
        ordy   = 1'b0;
        m_occ  = 0;
        m_ptr  = 0;
        m_lock = -1;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;
            pdat[i] = '0;
            plst[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        chk("init_ovld", 64'(ovld), 64'd0);
        chk("init_irdy", 64'(irdy), 64'd0);
        rst_n = 1'b1;

        // Fairness: every input always requesting, single-beat packets.
        repeat (12) step(4'hF, 100, 100, 100);
        // Backpressure: ordy held low for 5 cycles mid-stream.
        repeat (3) step(4'hF, 100, 100, 100);
        repeat (5) step(4'hF, 100, 0, 100);
        repeat (4) step(4'hF, 100, 100, 100);
        // Reset with O and S both full, then restart from input 0.
        repeat (3) step(4'hF, 100, 0, 100);
        do_reset();
        repeat (6) step(4'hF, 100, 100, 100);
        // Inputs 1 and 2 contend with multi-beat packets and gaps.
        repeat (40) step(4'b0110, 60, 100, 25);
        // Fully random traffic.
        repeat (300) step(4'hF, 50, 70, 40);
        // Flush: only last beats offered, then no new beats.
        repeat (20) step(4'hF, 100, 100, 100);
        repeat (20) step(4'h0, 0, 100, 0);
        // Sparse: only input 3 active.
        repeat (10) step(4'b1000, 100, 100, 100);
        repeat (6) step(4'h0, 0, 100, 0);

        npend = 0;
        for (int i = 0; i < N; i++) npend += int'(pend[i]);
        chk("drain_pending", 64'(npend), 64'd0);
        chk("drain_scoreboard", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
